// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one client port of the data-memory arbiter.
// The client (master) drives the request fields; the arbiter (slave) returns
// ready and the one-cycle completion response.
interface dmem_arbiter_if #(
  parameter int DWIDTH = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [1:0]        size;
  logic              is_unsigned;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              resp_valid;
  logic [DWIDTH-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output valid, we, size, is_unsigned, addr, wdata,
    input  ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  valid, we, size, is_unsigned, addr, wdata,
    output ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a 32-bit word-wide data memory.
// Byte/half/word requests become aligned word accesses; sub-word loads are
// extracted and extended, sub-word stores are done as read-modify-write.
module dmem_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     port0,
  dmem_arbiter_if.slave     port1,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

  state_t                   state;
  logic                     last_grant;
  logic                     lat_we;
  logic [1:0]               lat_size;
  logic                     lat_uns;
  logic [1:0]               lat_lane;
  logic [15:0]              lat_wdata;
  logic                     lat_port;
  logic [1:0]               resp_valid;
  logic [1:0]               resp_err;
  logic [1:0][DWIDTH-1:0]   resp_rdata;

  // Round-robin grant: a lone requester wins, a tie goes away from last_grant.
  logic              sel1;
  logic              accept;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_uns;
  logic [DWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [DWIDTH-1:0] req_aligned;
  logic              req_err;

  assign sel1   = port1.valid && (!port0.valid || !last_grant);
  assign accept = (state == IDLE) && (port0.valid || port1.valid);

  assign port0.ready = (state == IDLE) && port0.valid && !sel1;
  assign port1.ready = (state == IDLE) && sel1;

  assign req_we    = sel1 ? port1.we          : port0.we;
  assign req_size  = sel1 ? port1.size        : port0.size;
  assign req_uns   = sel1 ? port1.is_unsigned : port0.is_unsigned;
  assign req_addr  = sel1 ? port1.addr        : port0.addr;
  assign req_wdata = sel1 ? port1.wdata       : port0.wdata;

  // All error conditions are resolved here so a bad request never touches memory.
  assign req_aligned = {req_addr[DWIDTH-1:2], 2'b00};
  assign req_err = (req_size == 2'b11)
                || ((req_size == 2'b01) && req_addr[0])
                || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                || (req_aligned >= DWIDTH'(MEM_DEPTH - 3))
                || req_addr[DWIDTH-1];

  // Lane extraction for loads and lane merge for sub-word stores.
  logic [4:0]        shamt;
  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] load_val;
  logic [DWIDTH-1:0] size_mask;
  logic [DWIDTH-1:0] merged;

  assign shamt     = {lat_lane, 3'b000};
  assign shifted   = mem_rdata >> shamt;
  assign size_mask = (lat_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign merged    = (mem_rdata & ~(size_mask << shamt))
                   | (({16'h0000, lat_wdata} & size_mask) << shamt);

  // Extend the selected lane(s) according to size and the unsigned flag.
  always_comb begin
    load_val = shifted;
    case (lat_size)
      2'b00:   load_val = {{24{!lat_uns && shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{!lat_uns && shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Access sequencer: accept, drive the memory, optionally write back, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_uns      <= 1'b0;
      lat_lane     <= 2'b00;
      lat_wdata    <= '0;
      lat_port     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      resp_valid   <= '0;
      resp_err     <= '0;
      resp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= sel1;
            lat_port   <= sel1;
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_uns    <= req_uns;
            lat_lane   <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            if (req_err) begin
              resp_valid[sel1] <= 1'b1;
              resp_err[sel1]   <= 1'b1;
              resp_rdata[sel1] <= '0;
              state            <= RESP;
            end else begin
              mem_addr <= req_aligned;
              if (req_we && (req_size == 2'b10)) begin
                mem_write_en <= 1'b1;
                mem_wdata    <= req_wdata;
              end else begin
                mem_read_en  <= 1'b1;
              end
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          if (lat_we && (lat_size != 2'b10)) begin
            mem_write_en <= 1'b1;
            mem_wdata    <= merged;
            state        <= RMW_WR;
          end else begin
            resp_valid[lat_port] <= 1'b1;
            resp_err[lat_port]   <= 1'b0;
            resp_rdata[lat_port] <= lat_we ? '0 : load_val;
            state                <= RESP;
          end
        end
        RMW_WR: begin
          mem_write_en         <= 1'b0;
          resp_valid[lat_port] <= 1'b1;
          resp_err[lat_port]   <= 1'b0;
          resp_rdata[lat_port] <= '0;
          state                <= RESP;
        end
        default: begin
          resp_valid <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign port0.resp_valid = resp_valid[0];
  assign port0.resp_err   = resp_err[0];
  assign port0.resp_rdata = resp_rdata[0];
  assign port1.resp_valid = resp_valid[1];
  assign port1.resp_err   = resp_err[1];
  assign port1.resp_rdata = resp_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word memory behind the DUT, a byte-level reference
// model for expected load data, errors, latency and write counts.
module tb_dmem_arbiter;
  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en;

  dmem_arbiter_if #(.DWIDTH(32)) p0 ();
  dmem_arbiter_if #(.DWIDTH(32)) p1 ();

  dmem_arbiter #(.DWIDTH(32), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .port0(p0), .port1(p1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem_arr [0:255];
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (mem_write_en) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
      wr_cnt++;
    end
    if (mem_read_en) rd_cnt++;
    if (mem_read_en && mem_write_en) both_cnt++;
  end

  // Reference byte memory.
  logic [7:0] ref_mem [0:MEM_DEPTH-1];

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? p0.ready : p1.ready;
  endfunction
  function automatic logic rv(input int p);
    return (p == 0) ? p0.resp_valid : p1.resp_valid;
  endfunction

  task automatic drive(input int p, input bit v, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      p0.valid = v; p0.we = we; p0.size = sz; p0.is_unsigned = uns; p0.addr = a; p0.wdata = wd;
    end else begin
      p1.valid = v; p1.we = we; p1.size = sz; p1.is_unsigned = uns; p1.addr = a; p1.wdata = wd;
    end
  endtask

  // Expected behaviour of one request, derived byte-by-byte; stores update ref_mem.
  task automatic model(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int lat,
                       output int wr, output int rds);
    int n;
    int base;
    n    = 1 << sz;
    err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
        || ({a[31:2], 2'b00} >= 32'(MEM_DEPTH - 3)) || a[31];
    rd   = 32'h0;
    wr   = 0;
    rds  = 0;
    base = int'(a[9:0]);
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
      wr  = 1;
      rds = (n == 4) ? 0 : 1;
      lat = (n == 4) ? 2 : 3;
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[base + i]) << (8 * i));
      if (n < 4 && !uns && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
      rds = 1;
      lat = 2;
    end
  endtask

  // One complete transaction on port p, checked against the model.
  task automatic do_req(input int p, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] exp_rd;
    bit          exp_err, seen, err_seen;
    int          exp_lat, exp_wr, exp_rds, wr_b, rd_b, lat, oth;
    model(we, sz, uns, a, wd, exp_rd, exp_err, exp_lat, exp_wr, exp_rds);
    drive(p, 1, we, sz, uns, a, wd);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rdy(p)) begin seen = 1; break; end
    end
    check("accept_timeout", 32'(seen), 32'd1);
    wr_b = wr_cnt;
    rd_b = rd_cnt;
    @(posedge clk); #1;
    drive(p, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    seen = 0; lat = 0; oth = 0; got = 32'hx; err_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rv(1 - p)) oth++;
      if (rv(p)) begin
        seen = 1; lat = c;
        got      = (p == 0) ? p0.resp_rdata : p1.resp_rdata;
        err_seen = (p == 0) ? p0.resp_err : p1.resp_err;
        break;
      end
    end
    check("resp_timeout", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(err_seen), 32'(exp_err));
    check("resp_rdata", got, exp_rd);
    check("write_cycles", 32'(wr_cnt - wr_b), 32'(exp_wr));
    check("read_cycles", 32'(rd_cnt - rd_b), 32'(exp_rds));
    check("other_port_resp", 32'(oth), 32'd0);
    $display("txn port=%0d we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h",
             p, we, sz, uns, a, wd, lat, err_seen, got);
  endtask

  initial begin
    logic [31:0] r, w, a, e40, e80;
    logic [1:0]  sz;
    bit          d_err, seen;
    int          d_lat, d_wr, d_rds, wr_b, r0_b, r1_b, exp_g, got_g, owner, n_acc, pp;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem_arr[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);

    // Reset state
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready0", 32'(p0.ready), 32'd0);
    check("rst_ready1", 32'(p1.ready), 32'd0);
    check("rst_resp0", 32'(p0.resp_valid), 32'd0);
    check("rst_resp1", 32'(p1.resp_valid), 32'd0);
    check("rst_rd_en", 32'(mem_read_en), 32'd0);
    check("rst_wr_en", 32'(mem_write_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Word store then word load
    do_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, r);
    do_req(0, 0, 2'b10, 0, 32'h10, 32'h0, r);
    check("word_load_value", r, 32'hDEADBEEF);

    // Byte read-modify-write
    do_req(0, 1, 2'b10, 0, 32'h20, 32'h11223344, r);
    do_req(0, 1, 2'b00, 0, 32'h22, 32'h000000AB, r);
    do_req(0, 0, 2'b10, 0, 32'h20, 32'h0, r);
    check("rmw_word_value", r, 32'h11AB3344);

    // Sign / zero extension
    do_req(0, 1, 2'b10, 0, 32'h30, 32'h000080F0, r);
    do_req(0, 0, 2'b00, 0, 32'h30, 32'h0, r);
    check("byte_signed", r, 32'hFFFFFFF0);
    do_req(0, 0, 2'b00, 1, 32'h30, 32'h0, r);
    check("byte_unsigned", r, 32'h000000F0);
    do_req(0, 0, 2'b01, 0, 32'h30, 32'h0, r);
    check("half_signed", r, 32'hFFFF80F0);
    do_req(1, 1, 2'b01, 0, 32'h32, 32'h0000C001, r);
    do_req(1, 0, 2'b10, 0, 32'h30, 32'h0, r);
    check("half_store_value", r, 32'hC00180F0);

    // Errors
    do_req(0, 0, 2'b10, 0, 32'h13, 32'h0, r);
    do_req(0, 1, 2'b10, 0, 32'h3FE, 32'h12345678, r);
    do_req(1, 0, 2'b11, 0, 32'h40, 32'h0, r);
    do_req(1, 0, 2'b10, 0, 32'h8000_0040, 32'h0, r);
    do_req(0, 0, 2'b10, 0, 32'h3FC, 32'h0, r);

    // Reset asserted while the merged word is about to be written
    drive(0, 1, 1, 2'b00, 0, 32'h24, 32'h0000005A);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (p0.ready) begin seen = 1; break; end
    end
    check("mid_rst_accept", 32'(seen), 32'd1);
    wr_b = wr_cnt; r0_b = 0; r1_b = 0;
    @(posedge clk); #1;
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_in_rmw_wr", 32'(mem_write_en), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(mem_write_en), 32'd0);
    check("mid_rst_rd_en", 32'(mem_read_en), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (p0.resp_valid) r0_b++;
      if (p1.resp_valid) r1_b++;
    end
    check("mid_rst_no_write", 32'(wr_cnt - wr_b), 32'd0);
    check("mid_rst_no_resp", 32'(r0_b + r1_b), 32'd0);

    // Arbitration: both ports valid continuously from reset release
    model(0, 2'b10, 0, 32'h40, 32'h0, e40, d_err, d_lat, d_wr, d_rds);
    model(0, 2'b10, 0, 32'h80, 32'h0, e80, d_err, d_lat, d_wr, d_rds);
    drive(0, 1, 0, 2'b10, 0, 32'h40, 32'h0);
    drive(1, 1, 0, 2'b10, 0, 32'h80, 32'h0);
    rst = 1'b1;
    #1;
    exp_g = 0; owner = -1; n_acc = 0;
    for (int c = 0; c < 60 && n_acc < 6; c++) begin
      if (p0.resp_valid) begin
        check("arb_resp0_owner", 32'(owner), 32'd0);
        check("arb_resp0_rdata", p0.resp_rdata, e40);
      end
      if (p1.resp_valid) begin
        check("arb_resp1_owner", 32'(owner), 32'd1);
        check("arb_resp1_rdata", p1.resp_rdata, e80);
      end
      if (p0.ready || p1.ready) begin
        got_g = p1.ready ? 1 : 0;
        check("arb_grant", 32'(got_g), 32'(exp_g));
        $display("grant #%0d -> port %0d", n_acc, got_g);
        owner = got_g;
        exp_g = 1 - exp_g;
        n_acc++;
      end
      @(negedge clk);
    end
    check("arb_grant_count", 32'(n_acc), 32'd6);
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    repeat (6) @(negedge clk);

    // The aborted store must have left memory untouched
    do_req(0, 0, 2'b10, 0, 32'h24, 32'h0, r);

    // Randomized traffic against the model
    for (int k = 0; k < 80; k++) begin
      pp = int'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        8:       a = 32'h8000_0000 | 32'($urandom_range(0, 1023));
        9:       a = 32'($urandom_range(1016, 2047));
        default: a = 32'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(pp, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, r);
    end

    check("never_rd_and_wr", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
